uart_stream_bridge: RTL and testbench

Wishbone master that connects byte streams to the `uart1` Wishbone slave, in place of the hand-written echo state machine in the SoC top level. Upstream logic pushes TX bytes into a FIFO over a valid/ready port. The bridge issues paced write cycles to the UART CSR. On `irq_rx` it issues a read cycle and presents the received byte on a valid/ready output. It owns the Wishbone master signals previously driven by the top-level FSM.

---
 rtl/uart_stream_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_uart_stream_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_bridge.sv
// Wishbone master bridging a TX byte stream into the UART CSR and the UART RX
// interrupt back out to a valid/ready byte stream.
module uart_stream_bridge #(
  parameter logic [31:0] ADR         = 32'h0FF,
  parameter int          TX_DEPTH    = 16,
  parameter int          BYTE_GAP    = 25000,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic                        clk_48_i,
  input  logic                        rst_n_i,
  input  logic [7:0]                  tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  output logic [$clog2(TX_DEPTH):0]   tx_count_o,
  output logic [7:0]                  rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  input  logic                        irq_rx_i,
  output logic [31:0]                 wbm_adr_o,
  output logic [31:0]                 wbm_dat_o,
  input  logic [31:0]                 wbm_dat_i,
  output logic                        wbm_we_o,
  output logic [3:0]                  wbm_sel_o,
  output logic                        wbm_stb_o,
  output logic                        wbm_cyc_o,
  input  logic                        wbm_ack_i,
  output logic                        timeout_o
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int GW = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    WR_WAIT  = 2'd2,
    ACK_DROP = 2'd3
  } state_t;

  state_t        state_reg, state_next;

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          ready_reg;
  logic          push, pop;

  logic [GW-1:0] gap_reg, gap_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic [7:0]    rx_data_reg, rx_data_next;
  logic          rx_valid_reg, rx_valid_next;
  logic [31:0]   adr_reg, adr_next;
  logic [31:0]   dat_reg, dat_next;
  logic          we_reg, we_next;
  logic [3:0]    sel_reg, sel_next;
  logic          stb_reg, stb_next;
  logic          timeout_reg, timeout_next;

  // Only the low byte of the CSR carries data.
  logic          unused_dat;
  assign unused_dat = ^wbm_dat_i[31:8];

  assign tx_ready_o = ready_reg && (count_reg != (AW+1)'(TX_DEPTH));
  assign push       = tx_valid_i && tx_ready_o;

  always_ff @(posedge clk_48_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= tx_data_i;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gap_next      = (gap_reg != '0) ? gap_reg - GW'(1) : gap_reg;
    tmo_next      = tmo_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = rx_valid_reg && !rx_ready_i;
    adr_next      = adr_reg;
    dat_next      = dat_reg;
    we_next       = we_reg;
    sel_next      = sel_reg;
    stb_next      = stb_reg;
    timeout_next  = timeout_reg;
    pop           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (irq_rx_i && !rx_valid_reg) begin
          adr_next   = ADR;
          we_next    = 1'b0;
          sel_next   = 4'b0001;
          stb_next   = 1'b1;
          tmo_next   = '0;
          state_next = RD_WAIT;
        end else if (count_reg != '0 && gap_reg == '0) begin
          adr_next   = ADR;
          we_next    = 1'b1;
          dat_next   = {24'b0, fifo_mem[rd_ptr_reg]};
          sel_next   = 4'b0001;
          stb_next   = 1'b1;
          tmo_next   = '0;
          state_next = WR_WAIT;
        end
      end

      RD_WAIT: begin
        if (wbm_ack_i) begin
          rx_data_next  = wbm_dat_i[7:0];
          rx_valid_next = 1'b1;
          stb_next      = 1'b0;
          sel_next      = 4'b0000;
          state_next    = ACK_DROP;
        end else if (tmo_reg == TW'(ACK_TIMEOUT - 1)) begin
          stb_next     = 1'b0;
          sel_next     = 4'b0000;
          timeout_next = 1'b1;
          state_next   = ACK_DROP;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
      end

      WR_WAIT: begin
        // A timed-out byte is dropped just like an acked one so the stream never stalls.
        if (wbm_ack_i || tmo_reg == TW'(ACK_TIMEOUT - 1)) begin
          pop          = 1'b1;
          gap_next     = GW'(BYTE_GAP);
          stb_next     = 1'b0;
          sel_next     = 4'b0000;
          timeout_next = timeout_reg || !wbm_ack_i;
          state_next   = ACK_DROP;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
      end

      ACK_DROP: begin
        if (!wbm_ack_i) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_48_i) begin
    if (!rst_n_i) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ready_reg    <= 1'b0;
      gap_reg      <= '0;
      tmo_reg      <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      adr_reg      <= '0;
      dat_reg      <= '0;
      we_reg       <= 1'b0;
      sel_reg      <= '0;
      stb_reg      <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ready_reg    <= 1'b1;
      gap_reg      <= gap_next;
      tmo_reg      <= tmo_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      adr_reg      <= adr_next;
      dat_reg      <= dat_next;
      we_reg       <= we_next;
      sel_reg      <= sel_next;
      stb_reg      <= stb_next;
      timeout_reg  <= timeout_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + (AW+1)'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - (AW+1)'(1);
      end
    end
  end

  assign tx_count_o = count_reg;
  assign rx_data_o  = rx_data_reg;
  assign rx_valid_o = rx_valid_reg;
  assign wbm_adr_o  = adr_reg;
  assign wbm_dat_o  = dat_reg;
  assign wbm_we_o   = we_reg;
  assign wbm_sel_o  = sel_reg;
  assign wbm_stb_o  = stb_reg;
  assign wbm_cyc_o  = stb_reg;
  assign timeout_o  = timeout_reg;

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Directed bench for uart_stream_bridge: a small Wishbone slave model plus a
// strobe monitor; every expectation below is hand-derived.
module tb_uart_stream_bridge;

  localparam int GAP = 20;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [4:0]  tx_count;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        irq_rx = 1'b0;
  logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;
  logic        wbm_we, wbm_stb, wbm_cyc, wbm_ack;
  logic [3:0]  wbm_sel;
  logic        timeout;

  logic        ack_en = 1'b1;
  logic [7:0]  rd_byte = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_stream_bridge #(
    .ADR(32'h0FF), .TX_DEPTH(16), .BYTE_GAP(GAP), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk_48_i(clk), .rst_n_i(rst_n),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .tx_count_o(tx_count),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .irq_rx_i(irq_rx),
    .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we), .wbm_sel_o(wbm_sel), .wbm_stb_o(wbm_stb),
    .wbm_cyc_o(wbm_cyc), .wbm_ack_i(wbm_ack), .timeout_o(timeout)
  );

  // Slave: registered ack one cycle after it sees stb; upper data bits are junk.
  assign wbm_dat_i = {24'hABCDEF, rd_byte};
  always @(posedge clk) begin
    if (!rst_n) wbm_ack <= 1'b0;
    else        wbm_ack <= ack_en && wbm_stb && !wbm_ack;
  end

  typedef struct {
    int          t;
    logic        we;
    logic [31:0] dat;
    logic [31:0] adr;
    logic [3:0]  sel;
  } rec_t;

  rec_t log_q[$];
  int   cyc_n = 0;
  int   last_fall_t = 0;
  logic stb_q = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    rec_t r;
    if (wbm_stb && !stb_q) begin
      r.t = cyc_n; r.we = wbm_we; r.dat = wbm_dat_o; r.adr = wbm_adr; r.sel = wbm_sel;
      log_q.push_back(r);
      $display("txn %0d: t=%0d we=%0b adr=%h dat=%h sel=%b", log_q.size() - 1, cyc_n, wbm_we, wbm_adr, wbm_dat_o, wbm_sel);
    end
    if (!wbm_stb && stb_q) last_fall_t = cyc_n;
    stb_q = wbm_stb;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while (log_q.size() < n && b > 0) begin
      tick(1);
      b--;
    end
    chk(tag, (log_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int acc;
    int b;
    int base;

    // Reset state
    tick(3);
    chk("rst_stb", wbm_stb, 0);
    chk("rst_cyc", wbm_cyc, 0);
    chk("rst_count", tx_count, 0);
    chk("rst_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_adr", wbm_adr, 0);
    chk("rst_dat", wbm_dat_o, 0);
    chk("rst_we", wbm_we, 0);
    chk("rst_sel", wbm_sel, 0);
    rst_n = 1'b1;
    tick(1);
    chk("ready_after_release", tx_ready, 1);

    // Single TX byte: push at N, stb at N+1, ack seen at N+3
    tx_data = 8'h54; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    chk("single_count_push", tx_count, 1);
    chk("single_stb_not_yet", wbm_stb, 0);
    tick(1);
    chk("single_stb", wbm_stb, 1);
    chk("single_cyc", wbm_cyc, 1);
    chk("single_we", wbm_we, 1);
    chk("single_dat", wbm_dat_o, 32'h00000054);
    chk("single_adr", wbm_adr, 32'h000000FF);
    chk("single_sel", wbm_sel, 4'b0001);
    tick(1);
    chk("single_held_stb", wbm_stb, 1);
    chk("single_held_count", tx_count, 1);
    tick(1);
    chk("single_drop_stb", wbm_stb, 0);
    chk("single_count_done", tx_count, 0);

    // Burst of 17 during the 20-cycle gap: only 16 fit
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      tx_data = 8'(i); tx_valid = 1'b1;
      if (tx_ready) acc++;
      tick(1);
    end
    chk("burst_accepted", acc, 16);
    chk("burst_count_full", tx_count, 16);
    chk("burst_ready_low", tx_ready, 0);
    b = 200;
    while (!tx_ready && b > 0) begin
      tick(1);
      b--;
    end
    chk("burst_ready_returns", tx_ready, 1);
    tick(1);
    tx_valid = 1'b0;
    chk("burst_count_refill", tx_count, 16);
    wait_log("burst_wait", 18, 1000);
    tick(5);
    chk("burst_count_empty", tx_count, 0);
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("burst_dat_%0d", k), log_q[k].dat, (k == 0) ? 32'h54 : 32'(k - 1));
      chk($sformatf("burst_we_%0d", k), log_q[k].we, 1);
      chk($sformatf("burst_sel_%0d", k), log_q[k].sel, 4'b0001);
      if (k > 0)
        chk($sformatf("burst_spacing_%0d", k), (log_q[k].t - log_q[k-1].t >= GAP + 3) ? 32'd1 : 32'd0, 1);
    end

    // RX echo: irq at N -> stb after N, ack seen at N+2
    rd_byte = 8'h41; irq_rx = 1'b1;
    tick(1);
    chk("rx_stb", wbm_stb, 1);
    chk("rx_we", wbm_we, 0);
    chk("rx_adr", wbm_adr, 32'h000000FF);
    chk("rx_sel", wbm_sel, 4'b0001);
    tick(2);
    chk("rx_drop_stb", wbm_stb, 0);
    chk("rx_valid", rx_valid, 1);
    chk("rx_data", rx_data, 8'h41);
    tick(30);
    chk("rx_no_second_read", log_q.size(), 19);
    chk("rx_still_valid", rx_valid, 1);
    rx_ready = 1'b1; irq_rx = 1'b0;
    tick(1);
    rx_ready = 1'b0;
    chk("rx_consumed", rx_valid, 0);

    // Simultaneous irq and push: read first, write after
    tick(25);
    rd_byte = 8'h33; irq_rx = 1'b1;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    chk("sim_read_first_stb", wbm_stb, 1);
    chk("sim_read_first_we", wbm_we, 0);
    chk("sim_count", tx_count, 1);
    tick(2);
    irq_rx = 1'b0;
    chk("sim_rx_valid", rx_valid, 1);
    wait_log("sim_wait", 21, 60);
    chk("sim_order_read", log_q[19].we, 0);
    chk("sim_order_write", log_q[20].we, 1);
    chk("sim_write_dat", log_q[20].dat, 32'h000000A5);
    chk("sim_rx_data", rx_data, 8'h33);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(5);
    chk("sim_count_empty", tx_count, 0);

    // Ack timeout: stb high exactly 255 cycles, byte popped, flag sticky
    tick(25);
    ack_en = 1'b0;
    tx_data = 8'h77; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(2);
    chk("tmo_stb_up", wbm_stb, 1);
    chk("tmo_flag_clear", timeout, 0);
    b = 400;
    while (wbm_stb && b > 0) begin
      tick(1);
      b--;
    end
    chk("tmo_stb_fell", wbm_stb, 0);
    tick(1);
    chk("tmo_len", last_fall_t - log_q[21].t, TMO);
    chk("tmo_flag", timeout, 1);
    chk("tmo_popped", tx_count, 0);
    ack_en = 1'b1;
    tick(30);
    chk("tmo_sticky", timeout, 1);
    chk("tmo_no_retry", log_q.size(), 22);

    // Reset during WR_WAIT with 3 bytes queued
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'hC0 + 8'(i); tx_valid = 1'b1;
      tick(1);
    end
    tx_valid = 1'b0;
    chk("midrst_count3", tx_count, 3);
    chk("midrst_stb_up", wbm_stb, 1);
    chk("midrst_dat", log_q[22].dat, 32'h000000C0);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_stb", wbm_stb, 0);
    chk("midrst_cyc", wbm_cyc, 0);
    chk("midrst_count", tx_count, 0);
    chk("midrst_ready", tx_ready, 0);
    chk("midrst_timeout", timeout, 0);
    rst_n = 1'b1;
    ack_en = 1'b1;
    tick(1);
    chk("midrst_ready_after", tx_ready, 1);
    base = log_q.size();
    tick(20);
    chk("midrst_no_cycle", log_q.size(), base);
    chk("midrst_stb_idle", wbm_stb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
